// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 encodings, FSM states,
// access-fault detection and store lane steering.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      WAIT,
      RESP
   } lsu_state_t;

   // Stores only have B/H/W widths, so the unsigned encodings fault for them.
   function automatic logic access_fault(input logic       is_store,
                                         input logic [2:0] funct3,
                                         input logic [1:0] off);
      logic f;
      f = 1'b0;
      case (funct3)
         F3_B:    f = 1'b0;
         F3_H:    f = off[0];
         F3_W:    f = |off;
         F3_BU:   f = is_store;
         F3_HU:   f = is_store | off[0];
         default: f = 1'b1;
      endcase
      return f;
   endfunction

   function automatic logic [3:0] store_mask(input logic [2:0] funct3,
                                             input logic [1:0] off);
      logic [3:0] m;
      case (funct3)
         F3_B:    m = 4'b0001 << off;
         F3_H:    m = 4'b0011 << off;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   // Replicating into every lane lets the byte mask alone select the target bytes.
   function automatic logic [31:0] store_data(input logic [2:0]  funct3,
                                              input logic [31:0] wdata);
      logic [31:0] d;
      case (funct3)
         F3_B:    d = {4{wdata[7:0]}};
         F3_H:    d = {2{wdata[15:0]}};
         default: d = wdata;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and memory-port bundle of the load/store unit; the unit
// uses the slave view, the requester/memory side the master view.
interface load_store_unit_if #(
   parameter int ADDR_W = 10
);
   logic              req_valid;
   logic              req_ready;
   logic              req_is_store;
   logic [2:0]        req_funct3;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_fault;
   logic              mem_re;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_wmask;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   modport slave (
      input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_fault,
             mem_re, mem_we, mem_addr, mem_wmask, mem_wdata
   );

   modport master (
      output req_valid, req_is_store, req_funct3, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_fault,
             mem_re, mem_we, mem_addr, mem_wmask, mem_wdata
   );
endinterface

// File: rtl/load_store_unit_load_extend.sv
// Combinational load data alignment: selects the byte/half addressed by
// byte_off out of a memory word and sign- or zero-extends it per funct3.
module load_extend
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  byte_off,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [7:0]  sel_b;
   logic [15:0] sel_h;

   always_comb begin
      case (byte_off)
         2'd0:    sel_b = rdata[7:0];
         2'd1:    sel_b = rdata[15:8];
         2'd2:    sel_b = rdata[23:16];
         default: sel_b = rdata[31:24];
      endcase
      sel_h = byte_off[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      case (funct3)
         F3_B:    data = {{24{sel_b[7]}}, sel_b};
         F3_BU:   data = {24'd0, sel_b};
         F3_H:    data = {{16{sel_h[15]}}, sel_h};
         F3_HU:   data = {16'd0, sel_h};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage: fault 1 cycle, store 2, load 2+MEM_LAT cycles after accept.
// req_ready is high only in IDLE; requests presented while busy are not queued.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int MEM_LAT = 1
) (
   input logic              clk,
   input logic              rst_n,
   load_store_unit_if.slave bus
);

   localparam logic [2:0] LAT = 3'(MEM_LAT);

   lsu_state_t        state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              is_store_q, is_store_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [1:0]        off_q, off_d;

   logic              req_ready_q, req_ready_d;
   logic              resp_valid_q, resp_valid_d;
   logic              resp_fault_q, resp_fault_d;
   logic [31:0]       resp_rdata_q, resp_rdata_d;
   logic              mem_re_q, mem_re_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [3:0]        mem_wmask_q, mem_wmask_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;

   logic              accept;
   logic              req_fault;
   logic [31:0]       load_data;
   logic              unused_addr_hi;

   assign accept         = bus.req_valid && req_ready_q;
   assign req_fault      = access_fault(bus.req_is_store, bus.req_funct3, bus.req_addr[1:0]);
   // Byte address bits above the memory's word range are dropped on purpose.
   assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

   load_extend u_load_extend (
      .rdata    (bus.mem_rdata),
      .byte_off (off_q),
      .funct3   (funct3_q),
      .data     (load_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         is_store_q   <= 1'b0;
         funct3_q     <= '0;
         off_q        <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_fault_q <= 1'b0;
         resp_rdata_q <= '0;
         mem_re_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wmask_q  <= '0;
         mem_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         is_store_q   <= is_store_d;
         funct3_q     <= funct3_d;
         off_q        <= off_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_fault_q <= resp_fault_d;
         resp_rdata_q <= resp_rdata_d;
         mem_re_q     <= mem_re_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wmask_q  <= mem_wmask_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   // Outputs are registered, so each state computes the values seen in the next cycle.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      is_store_d   = is_store_q;
      funct3_d     = funct3_q;
      off_d        = off_q;
      req_ready_d  = 1'b0;
      resp_valid_d = 1'b0;
      resp_fault_d = 1'b0;
      resp_rdata_d = resp_rdata_q;
      mem_re_d     = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wmask_d  = '0;
      mem_wdata_d  = '0;

      case (state_q)
         IDLE: begin
            req_ready_d = 1'b1;
            if (accept) begin
               req_ready_d = 1'b0;
               is_store_d  = bus.req_is_store;
               funct3_d    = bus.req_funct3;
               off_d       = bus.req_addr[1:0];
               if (req_fault) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_fault_d = 1'b1;
                  resp_rdata_d = '0;
               end else begin
                  state_d    = ACCESS;
                  mem_addr_d = bus.req_addr[ADDR_W+1:2];
                  if (bus.req_is_store) begin
                     mem_we_d    = 1'b1;
                     mem_wmask_d = store_mask(bus.req_funct3, bus.req_addr[1:0]);
                     mem_wdata_d = store_data(bus.req_funct3, bus.req_wdata);
                  end else begin
                     mem_re_d = 1'b1;
                  end
               end
            end
         end
         ACCESS: begin
            if (is_store_q) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_rdata_d = '0;
            end else begin
               state_d = WAIT;
               cnt_d   = 3'd1;
            end
         end
         WAIT: begin
            if (cnt_q == LAT) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_rdata_d = load_data;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         RESP: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_fault = resp_fault_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.mem_re     = mem_re_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wmask  = mem_wmask_q;
   assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: two instances (MEM_LAT 1 and 3) share
// one request driver and a byte-masked memory model with per-instance read pipelines.
module tb_load_store_unit;

   typedef struct {
      logic [31:0] rd;
      logic        flt;
      int          t;
   } resp_e_t;

   typedef struct {
      logic        we;
      logic [9:0]  adr;
      logic [3:0]  mask;
      logic [31:0] wd;
      int          t;
   } mem_e_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sel = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_is_store = 1'b0;
   logic [2:0]  req_funct3 = '0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;

   int cyc = 0;
   int total = 0;
   int bad = 0;

   resp_e_t rq[$];
   mem_e_t  mq[$];
   resp_e_t mon_r;
   mem_e_t  mon_m;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   load_store_unit_if #(.ADDR_W(10)) ifa ();
   load_store_unit_if #(.ADDR_W(10)) ifb ();

   load_store_unit #(.ADDR_W(10), .MEM_LAT(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
   load_store_unit #(.ADDR_W(10), .MEM_LAT(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

   assign ifa.req_valid    = req_valid & ~sel;
   assign ifb.req_valid    = req_valid & sel;
   assign ifa.req_is_store = req_is_store;
   assign ifb.req_is_store = req_is_store;
   assign ifa.req_funct3   = req_funct3;
   assign ifb.req_funct3   = req_funct3;
   assign ifa.req_addr     = req_addr;
   assign ifb.req_addr     = req_addr;
   assign ifa.req_wdata    = req_wdata;
   assign ifb.req_wdata    = req_wdata;

   // Memory model: byte-masked writes, reads delayed by each instance's latency.
   logic [31:0] mem [0:1023];
   logic [31:0] pa_a, pa_b0, pa_b1, pa_b2;
   logic [3:0]  pv_a = '0;
   logic [3:0]  pv_b = '0;

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (ifa.mem_we && ifa.mem_wmask[i]) mem[ifa.mem_addr][8*i +: 8] <= ifa.mem_wdata[8*i +: 8];
         if (ifb.mem_we && ifb.mem_wmask[i]) mem[ifb.mem_addr][8*i +: 8] <= ifb.mem_wdata[8*i +: 8];
      end
      pv_a  <= {pv_a[2:0], ifa.mem_re};
      pa_a  <= mem[ifa.mem_addr];
      pv_b  <= {pv_b[2:0], ifb.mem_re};
      pa_b0 <= mem[ifb.mem_addr];
      pa_b1 <= pa_b0;
      pa_b2 <= pa_b1;
   end

   assign ifa.mem_rdata = pv_a[0] ? pa_a  : 32'hBAD0_BAD0;
   assign ifb.mem_rdata = pv_b[2] ? pa_b2 : 32'hBAD0_BAD0;

   logic        m_req_ready, m_resp_valid, m_resp_fault, m_mem_re, m_mem_we;
   logic [31:0] m_resp_rdata, m_mem_wdata;
   logic [9:0]  m_mem_addr;
   logic [3:0]  m_mem_wmask;

   assign m_req_ready  = sel ? ifb.req_ready  : ifa.req_ready;
   assign m_resp_valid = sel ? ifb.resp_valid : ifa.resp_valid;
   assign m_resp_fault = sel ? ifb.resp_fault : ifa.resp_fault;
   assign m_resp_rdata = sel ? ifb.resp_rdata : ifa.resp_rdata;
   assign m_mem_re     = sel ? ifb.mem_re     : ifa.mem_re;
   assign m_mem_we     = sel ? ifb.mem_we     : ifa.mem_we;
   assign m_mem_addr   = sel ? ifb.mem_addr   : ifa.mem_addr;
   assign m_mem_wmask  = sel ? ifb.mem_wmask  : ifa.mem_wmask;
   assign m_mem_wdata  = sel ? ifb.mem_wdata  : ifa.mem_wdata;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard whenever the selected DUT presents a response or access.
   always @(negedge clk) begin
      if (rst_n) begin
         if (m_resp_valid) begin
            if (rq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_resp: got resp_valid expected none (cycle %0d)", cyc);
            end else begin
               mon_r = rq.pop_front();
               check("resp_rdata", m_resp_rdata, mon_r.rd);
               check("resp_fault", 32'(m_resp_fault), 32'(mon_r.flt));
               check("resp_cycle", 32'(cyc), 32'(mon_r.t));
            end
         end
         if (m_mem_re || m_mem_we) begin
            if (mq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_mem: got re=%0b we=%0b expected none (cycle %0d)",
                        m_mem_re, m_mem_we, cyc);
            end else begin
               mon_m = mq.pop_front();
               check("mem_we", 32'(m_mem_we), 32'(mon_m.we));
               check("mem_re", 32'(m_mem_re), 32'(!mon_m.we));
               check("mem_addr", 32'(m_mem_addr), 32'(mon_m.adr));
               check("mem_wmask", 32'(m_mem_wmask), 32'(mon_m.mask));
               check("mem_wdata", m_mem_wdata, mon_m.wd);
               check("mem_cycle", 32'(cyc), 32'(mon_m.t));
            end
         end
         if (!m_mem_we) begin
            check("idle_wmask", 32'(m_mem_wmask), 32'd0);
            check("idle_wdata", m_mem_wdata, 32'd0);
         end
      end
   end

   // Presents one request (held until accepted) and queues its expected outcome.
   task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [9:0] madr, input logic [3:0] mask,
                        input logic [31:0] mwd, input logic [31:0] rd, input logic flt,
                        input logic push_resp, output int t_acc);
      resp_e_t r;
      mem_e_t  m;
      int      lat;
      bit      done;
      lat          = sel ? 3 : 1;
      done         = 1'b0;
      t_acc        = -1;
      req_valid    = 1'b1;
      req_is_store = st;
      req_funct3   = f3;
      req_addr     = addr;
      req_wdata    = wd;
      for (int n = 0; n < 60 && !done; n++) begin
         if (m_req_ready) begin
            done  = 1'b1;
            t_acc = cyc;
            r.rd  = rd;
            r.flt = flt;
            r.t   = flt ? t_acc + 1 : (st ? t_acc + 2 : t_acc + 2 + lat);
            if (push_resp) rq.push_back(r);
            if (!flt) begin
               m.we   = st;
               m.adr  = madr;
               m.mask = mask;
               m.wd   = mwd;
               m.t    = t_acc + 1;
               mq.push_back(m);
            end
         end
         @(negedge clk);
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: got req_ready=0 for 60 cycles expected accept");
      end
   endtask

   task automatic load_set();
      int t;
      issue(0, 3'd0, 32'h11, 0, 10'd4, 4'h0, 0, 32'h0000_007F, 0, 1, t);
      issue(0, 3'd0, 32'h12, 0, 10'd4, 4'h0, 0, 32'hFFFF_FFFF, 0, 1, t);
      issue(0, 3'd4, 32'h13, 0, 10'd4, 4'h0, 0, 32'h0000_0080, 0, 1, t);
      issue(0, 3'd1, 32'h12, 0, 10'd4, 4'h0, 0, 32'hFFFF_80FF, 0, 1, t);
      issue(0, 3'd5, 32'h10, 0, 10'd4, 4'h0, 0, 32'h0000_7F01, 0, 1, t);
      issue(0, 3'd2, 32'h10, 0, 10'd4, 4'h0, 0, 32'h80FF_7F01, 0, 1, t);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && (rq.size() != 0 || mq.size() != 0); i++) @(negedge clk);
      check("drain_resp_left", 32'(rq.size()), 32'd0);
      check("drain_mem_left", 32'(mq.size()), 32'd0);
   endtask

   initial begin
      int t, t1, t2;
      repeat (2) @(negedge clk);
      check("rst_a_req_ready", 32'(ifa.req_ready), 32'd1);
      check("rst_a_resp_valid", 32'(ifa.resp_valid), 32'd0);
      check("rst_a_resp_rdata", ifa.resp_rdata, 32'd0);
      check("rst_a_resp_fault", 32'(ifa.resp_fault), 32'd0);
      check("rst_a_mem_strobes", {30'd0, ifa.mem_re, ifa.mem_we}, 32'd0);
      check("rst_a_mem_addr", 32'(ifa.mem_addr), 32'd0);
      check("rst_b_req_ready", 32'(ifb.req_ready), 32'd1);
      check("rst_b_resp_valid", 32'(ifb.resp_valid), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Stores on the MEM_LAT=1 instance, including address truncation.
      issue(1, 3'd2, 32'h8,      32'hDEAD_BEEF, 10'd2, 4'hF, 32'hDEAD_BEEF, 0, 0, 1, t);
      issue(1, 3'd0, 32'h3,      32'h0000_00A5, 10'd0, 4'h8, 32'hA5A5_A5A5, 0, 0, 1, t);
      issue(1, 3'd1, 32'h2,      32'h0000_1234, 10'd0, 4'hC, 32'h1234_1234, 0, 0, 1, t);
      issue(1, 3'd2, 32'h1000,   32'h1122_3344, 10'd0, 4'hF, 32'h1122_3344, 0, 0, 1, t);
      issue(1, 3'd2, 32'h10,     32'h80FF_7F01, 10'd4, 4'hF, 32'h80FF_7F01, 0, 0, 1, t);
      load_set();

      // Faults: misaligned or illegal funct3, never touching memory.
      issue(0, 3'd2, 32'h6,  0,       10'd0, 4'h0, 0, 0, 1, 1, t);
      issue(1, 3'd1, 32'h1,  32'h55,  10'd0, 4'h0, 0, 0, 1, 1, t);
      issue(0, 3'd3, 32'h10, 0,       10'd0, 4'h0, 0, 0, 1, 1, t);
      issue(1, 3'd4, 32'h10, 32'h77,  10'd0, 4'h0, 0, 0, 1, 1, t);
      issue(0, 3'd5, 32'h13, 0,       10'd0, 4'h0, 0, 0, 1, 1, t);

      // Request held while busy: second one lands the cycle after RESP.
      issue(0, 3'd2, 32'h10, 0, 10'd4, 4'h0, 0, 32'h80FF_7F01, 0, 1, t1);
      issue(0, 3'd4, 32'h13, 0, 10'd4, 4'h0, 0, 32'h0000_0080, 0, 1, t2);
      req_valid = 1'b0;
      check("held_req_accept_gap", 32'(t2 - t1), 32'd4);
      drain();

      sel = 1'b1;
      @(negedge clk);
      load_set();
      drain();

      // Reset during a load's WAIT on the MEM_LAT=3 instance.
      issue(0, 3'd2, 32'h10, 0, 10'd4, 4'h0, 0, 0, 0, 0, t);
      req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_req_ready", 32'(ifb.req_ready), 32'd1);
      check("abort_resp_valid", 32'(ifb.resp_valid), 32'd0);
      check("abort_resp_rdata", ifb.resp_rdata, 32'd0);
      repeat (10) @(negedge clk);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish by 200000");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle load/store stage directly downstream of the ALU.
- Takes the ALU result as the effective byte address, together with the RISC-V funct3 and the rs2 store data.
- Issues one word-wide access to a synchronous on-chip memory, then returns aligned and extended load data to writeback.
- Uses a valid/ready request handshake and a single-cycle response strobe, so the core controller stalls while the unit is busy.

Parameters:
- ADDR_W, 10: memory word-address width; byte address bits [ADDR_W+1:2] are used, upper bits are ignored.
- MEM_LAT, 1: read latency of the memory in cycles, counted from the mem_re cycle to the cycle mem_rdata is valid; legal range 1..4.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle; a request is accepted on req_valid && req_ready.
- req_is_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; for stores 0 SB, 1 SH, 2 SW.
- req_addr  in  32  effective byte address (ALU out).
- req_wdata  in  32  store data (rs2).
- resp_valid  out  1  one-cycle completion strobe.
- resp_rdata  out  32  load result; 0 for stores and faults.
- resp_fault  out  1  misaligned access or illegal funct3, qualified by resp_valid.
- mem_re  out  1  memory read strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory word address.
- mem_wmask  out  4  byte enables; bit i enables byte lane i.
- mem_wdata  out  32  lane-shifted store data.
- mem_rdata  in  32  memory read data.

Behaviour:
- The clock is clk and reset is rst_n: one clock domain, reset synchronous and active-low.
- All outputs are registered. Reset values:
  - req_ready = 1.
  - All other outputs 0, including resp_rdata.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On accept, latch is_store, funct3, addr[ADDR_W+1:0] and wdata.
  - On accept, drop req_ready the next cycle.
  - Fault check at accept:
    - H-size with addr[0] = 1 is a fault.
    - W-size with addr[1:0] != 0 is a fault.
    - Load funct3 in {3,6,7} is a fault.
    - Store funct3 > 2 is a fault.
  - Fault -> RESP, with no memory strobe ever asserted. Otherwise -> ACCESS.
- ACCESS (one cycle):
  - Store: mem_we = 1 and mem_addr set.
    - Masks: SB 4'b0001 << addr[1:0]; SH 4'b0011 << addr[1:0]; SW 4'b1111.
    - Data: SB replicates wdata[7:0] into all four lanes; SH replicates wdata[15:0] into both halves; SW passes wdata unchanged.
    - Next state RESP.
  - Load: mem_re = 1 and mem_addr set; next state WAIT.
- WAIT:
  - Counter counts MEM_LAT cycles after the mem_re cycle.
  - On the cycle mem_rdata is valid, extract the byte or half selected by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW is unchanged.
  - Register the result into resp_rdata, then -> RESP.
- RESP (one cycle):
  - resp_valid = 1; resp_fault is valid in this cycle.
  - Next state IDLE, with req_ready = 1 in the following cycle.
  - resp_rdata holds its value until the next response.
- Strobes: mem_re and mem_we are each high for exactly one cycle per access and are never high together. mem_wmask and mem_wdata are 0 whenever mem_we = 0.
- Latency from the accept cycle T:
  - Fault: resp_valid at T+1.
  - Store: mem_we at T+1, resp_valid at T+2.
  - Load: mem_re at T+1, data sampled at T+1+MEM_LAT, resp_valid at T+2+MEM_LAT.
- Boundary conditions:
  - req_valid while busy is ignored and not queued; the requester holds its request.
  - The word address truncates silently: byte address 0x0000_1000 with ADDR_W = 10 gives mem_addr = 0.
  - Reset mid-operation: return to IDLE, all outputs go to reset values, no pending write is issued, and in-flight read data is discarded.
  - A new request accepted in the cycle after RESP is legal, giving back-to-back operation.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - typedef enum lsu_state_t {IDLE, ACCESS, WAIT, RESP}.
- One combinational sub-module, load_extend: inputs rdata[31:0], byte_off[1:0], funct3[2:0]; output data[31:0].

Test Plan:
- Reset, then SW of 0xDEADBEEF at 0x0000_0008: mem_we at T+1, mem_addr = 2, mask 4'b1111, wdata 0xDEADBEEF; resp_valid at T+2, fault = 0.
- SB of 0x0000_00A5 at 0x0000_0003: mem_wmask = 4'b1000, mem_wdata = 0xA5A5A5A5. Then SH of 0x1234 at 0x0000_0002: mask 4'b1100.
- Loads with memory word = 0x80FF7F01 at byte address 0x0000_0010 (mem_addr 4):
  - LB +1 -> 0x0000007F.
  - LB +2 -> 0xFFFFFFFF.
  - LBU +3 -> 0x00000080.
  - LH +2 -> 0xFFFF80FF.
  - LHU +0 -> 0x00007F01.
  - LW -> 0x80FF7F01.
  - resp_valid at T+3 (MEM_LAT = 1); repeat with MEM_LAT = 3 and expect T+5.
- Faults: LW at 0x0000_0006 and SH at 0x0000_0001 each give resp_valid at T+1 with fault = 1, rdata = 0, and no mem_re or mem_we. Load funct3 = 3 gives the same response.
- Request held high while busy: only one access is issued; the second request is accepted in the cycle after RESP.
- rst_n low during a load's WAIT: the next cycle has req_ready = 1 and resp_valid = 0, and resp_valid never fires for the aborted load.
